// File: rtl/sdram_stream_reader.sv
// Two-client 128-bit word reader on a 16-bit SDRAM burst port; audio has priority, bounded by a streak limit.
// Optional read watchdog enabled by defining SDRAM_RD_TIMEOUT_EN (adds TIMEOUT parameter, drives rd_err).
//
// state     | meaning
// S_IDLE    | wait for init_done and a request, arbitrate, latch address
// S_ISSUE   | mem_req held until controller accepts
// S_COLLECT | pack 16-bit beats into the 128-bit word
// S_DONE    | word on a_data/v_data, one-cycle ac pulse
module sdram_stream_reader #(
  parameter int A_STREAK_MAX = 4
`ifdef SDRAM_RD_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic         Clk50,
  input  logic         reset_n,
  input  logic         init_done,
  input  logic         a_rd,
  input  logic [21:0]  a_addr,
  output logic         a_wait,
  output logic         a_ac,
  output logic [127:0] a_data,
  input  logic         v_rd,
  input  logic [21:0]  v_addr,
  output logic         v_ac,
  output logic [127:0] v_data,
  output logic         mem_req,
  output logic [24:0]  mem_addr,
  input  logic         mem_ready,
  input  logic         mem_rvalid,
  input  logic [15:0]  mem_rdata,
  output logic         rd_err
);

  localparam int BEATS = 8;
  localparam int SW = $clog2(A_STREAK_MAX + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state;
  logic          grant_v;
  logic [2:0]    beat_cnt;
  logic [SW-1:0] streak;
  logic [127:0]  word;
  logic [127:0]  word_nxt;
  logic          streak_full;
  logic          pick_v;
  logic          beat_take;
  logic          last_beat;
  logic          wd_expire;
  logic          finish;

  assign streak_full = (streak == SW'(A_STREAK_MAX));
  assign pick_v      = v_rd && (!a_rd || streak_full);
  assign mem_req     = (state == S_ISSUE);
  assign a_wait      = !init_done || (state != S_IDLE && grant_v) ||
                       (state == S_IDLE && v_rd && streak_full);

  // A beat arriving together with mem_ready already belongs to the burst.
  assign beat_take = mem_rvalid && ((state == S_ISSUE && mem_ready) || state == S_COLLECT);
  assign last_beat = beat_take && (beat_cnt == 3'(BEATS - 1));
  assign finish    = (state == S_COLLECT && last_beat) || wd_expire;

  always_comb begin
    word_nxt = word;
    if (beat_take) word_nxt[{beat_cnt, 4'b0000} +: 16] = mem_rdata;
  end

`ifdef SDRAM_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  assign wd_expire = (state == S_ISSUE || state == S_COLLECT) && (wd_cnt == '0);

  always_ff @(posedge Clk50 or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      rd_err <= 1'b0;
    end else begin
      if (state == S_IDLE) wd_cnt <= TW'(TIMEOUT - 1);
      else if (wd_cnt != '0) wd_cnt <= wd_cnt - TW'(1);
      if (wd_expire) rd_err <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign rd_err    = 1'b0;
`endif

  always_ff @(posedge Clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      grant_v  <= 1'b0;
      beat_cnt <= '0;
      streak   <= '0;
      word     <= '0;
      mem_addr <= '0;
      a_data   <= '0;
      v_data   <= '0;
      a_ac     <= 1'b0;
      v_ac     <= 1'b0;
    end else begin
      a_ac <= 1'b0;
      v_ac <= 1'b0;
      if (beat_take) begin
        word     <= word_nxt;
        beat_cnt <= beat_cnt + 3'd1;
      end
      case (state)
        S_IDLE: begin
          if (init_done && (a_rd || v_rd)) begin
            grant_v  <= pick_v;
            word     <= '0;
            beat_cnt <= '0;
            state    <= S_ISSUE;
            if (pick_v) begin
              streak   <= '0;
              mem_addr <= {v_addr, 3'b000};
            end else begin
              mem_addr <= {a_addr, 3'b000};
              if (!streak_full) streak <= streak + SW'(1);
            end
          end
          // The streak only means something while video is actually waiting.
          if (!v_rd) streak <= '0;
        end
        S_ISSUE: begin
          if (mem_ready) state <= S_COLLECT;
        end
        S_COLLECT: begin
        end
        default: state <= S_IDLE;
      endcase
      if (finish) begin
        state <= S_DONE;
        if (grant_v) begin
          v_data <= word_nxt;
          v_ac   <= 1'b1;
        end else begin
          a_data <= word_nxt;
          a_ac   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Randomized bench for sdram_stream_reader: behavioural SDRAM responder plus word-level reference model.
module tb_sdram_stream_reader;

  logic         Clk50 = 1'b0;
  logic         reset_n, init_done, a_rd, v_rd;
  logic [21:0]  a_addr, v_addr;
  logic         a_wait, a_ac, v_ac, mem_req, mem_ready, mem_rvalid, rd_err;
  logic [127:0] a_data, v_data;
  logic [24:0]  mem_addr;
  logic [15:0]  mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  bit          seq_mode = 1'b0;
  bit          junk_en = 1'b0;
  bit          resp_busy = 1'b0;
  int          pause_after = -1;
  int          beats_sent = 0;
  int          bursts = 0;
  logic [24:0] last_mem_addr = '0;

  sdram_stream_reader dut (
    .Clk50(Clk50), .reset_n(reset_n), .init_done(init_done),
    .a_rd(a_rd), .a_addr(a_addr), .a_wait(a_wait), .a_ac(a_ac), .a_data(a_data),
    .v_rd(v_rd), .v_addr(v_addr), .v_ac(v_ac), .v_data(v_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rd_err(rd_err)
  );

  always #5 Clk50 = ~Clk50;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the 16-bit-word address, or 1..8 for the datasheet example.
  function automatic logic [15:0] beat_val(input logic [24:0] a, input int i);
    logic [24:0] x;
    x = a + 25'(i);
    if (seq_mode) return 16'(i + 1);
    return x[15:0] ^ {x[24:16], 7'h2b};
  endfunction

  function automatic logic [127:0] exp_word(input logic [21:0] addr);
    logic [127:0] w;
    for (int i = 0; i < 8; i++) w[16*i +: 16] = beat_val({addr, 3'b000}, i);
    return w;
  endfunction

  // Responder: accept after 0-2 cycles, then 8 beats with random gaps; stray beats when idle.
  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge Clk50);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (mem_req && reset_n) begin
        resp_busy = 1'b1;
        repeat ($urandom_range(0, 2)) @(negedge Clk50);
        mem_ready = 1'b1; last_mem_addr = mem_addr; bursts++; beats_sent = 0;
        for (int i = 0; i < 8; i++) begin
          if (i > 0 || $urandom_range(0, 3) != 0) begin
            @(negedge Clk50);
            mem_ready = 1'b0; mem_rvalid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge Clk50);
            if (i == pause_after) repeat (8) @(negedge Clk50);
          end
          mem_rvalid = 1'b1; mem_rdata = beat_val(last_mem_addr, i); beats_sent = i + 1;
        end
        @(negedge Clk50);
        mem_ready = 1'b0; mem_rvalid = 1'b0; resp_busy = 1'b0;
      end else if (junk_en && $urandom_range(0, 7) == 0) begin
        mem_rvalid = 1'b1; mem_rdata = 16'($urandom);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t, b0, acs, exp_v;
    bit flag_a, flag_b;
    logic [21:0] ad, vd;
    reset_n = 1'b0; init_done = 1'b0; a_rd = 1'b0; v_rd = 1'b0; a_addr = '0; v_addr = '0;
    repeat (3) @(negedge Clk50);
    reset_n = 1'b1;
    @(negedge Clk50);
    check_val("rst_a_ac", a_ac, 0);
    check_val("rst_v_ac", v_ac, 0);
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_a_data", a_data, 0);

    // Requests held off until the controller reports init done.
    seq_mode = 1'b1; a_addr = 22'h00010; a_rd = 1'b1;
    flag_a = 1'b0; flag_b = 1'b0;
    repeat (12) begin
      @(negedge Clk50);
      if (mem_req) flag_a = 1'b1;
      if (!a_wait) flag_b = 1'b1;
    end
    check_val("req_before_init", flag_a, 0);
    check_val("a_wait_low_before_init", flag_b, 0);
    init_done = 1'b1;
    flag_a = 1'b0; t = 0;
    while (!a_ac && t < 500) begin @(negedge Clk50); if (v_ac) flag_a = 1'b1; t++; end
    check_val("ex_a_ac_seen", a_ac, 1);
    check_val("ex_mem_addr", last_mem_addr, 25'h80);
    check_val("ex_a_data", a_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    @(negedge Clk50);
    check_val("ex_a_ac_pulse", a_ac, 0);
    a_rd = 1'b0;
    check_val("ex_v_ac_quiet", flag_a, 0);
    check_val("ex_v_data", v_data, 0);
    seq_mode = 1'b0;

    // Reset in the middle of collection; the leftover beats land in IDLE.
    repeat (3) @(negedge Clk50);
    ad = 22'($urandom) | 22'h1; a_addr = ad; a_rd = 1'b1; pause_after = 3;
    t = 0;
    while (!(resp_busy && beats_sent == 3) && t < 500) begin @(negedge Clk50); t++; end
    check_val("rst_mid_reached", beats_sent, 3);
    @(negedge Clk50);
    reset_n = 1'b0; a_rd = 1'b0;
    #1;
    check_val("rstmid_a_data", a_data, 0);
    check_val("rstmid_mem_addr", mem_addr, 0);
    check_val("rstmid_mem_req", mem_req, 0);
    @(negedge Clk50);
    reset_n = 1'b1; pause_after = -1;
    flag_a = 1'b0; t = 0;
    while (resp_busy && t < 500) begin @(negedge Clk50); if (a_ac || v_ac) flag_a = 1'b1; t++; end
    check_val("rstmid_no_ac", flag_a, 0);
    repeat (2) @(negedge Clk50);
    ad = 22'($urandom); a_addr = ad; a_rd = 1'b1;
    t = 0;
    while (!a_ac && t < 500) begin @(negedge Clk50); t++; end
    check_val("rstmid_fresh_ac", a_ac, 1);
    check_val("rstmid_fresh_data", a_data, exp_word(ad));
    @(negedge Clk50);
    a_rd = 1'b0;
    repeat (3) @(negedge Clk50);

    // Both clients held high: audio x4 then one forced video grant, repeating.
    b0 = bursts;
    ad = 22'($urandom); vd = 22'($urandom);
    a_addr = ad; v_addr = vd; a_rd = 1'b1; v_rd = 1'b1;
    for (int k = 0; k < 10; k++) begin
      t = 0;
      while (!(a_ac || v_ac) && t < 500) begin @(negedge Clk50); t++; end
      exp_v = (k % 5 == 4) ? 1 : 0;
      check_val("grant_order", {a_ac, v_ac}, exp_v ? 2'b01 : 2'b10);
      if (v_ac) begin
        check_val("streak_v_data", v_data, exp_word(vd));
        check_val("a_wait_in_v_burst", a_wait, 1);
      end else begin
        check_val("streak_a_data", a_data, exp_word(ad));
      end
      @(negedge Clk50);
    end
    a_rd = 1'b0; v_rd = 1'b0;
    t = 0;
    while ((resp_busy || mem_req) && t < 500) begin @(negedge Clk50); t++; end
    repeat (3) @(negedge Clk50);
    check_val("streak_burst_count", bursts - b0, 10);

    // Random traffic from both clients with stray beats on the bus.
    junk_en = 1'b1; b0 = bursts; acs = 0;
    fork
      begin
        int ta;
        logic [21:0] aa;
        for (int k = 0; k < 12; k++) begin
          ta = 0;
          while (a_wait && ta < 3000) begin @(negedge Clk50); ta++; end
          aa = 22'($urandom); a_addr = aa; a_rd = 1'b1;
          ta = 0;
          @(negedge Clk50);
          while (!a_ac && ta < 3000) begin @(negedge Clk50); ta++; end
          check_val("rnd_a_ac_seen", a_ac, 1);
          check_val("rnd_a_data", a_data, exp_word(aa));
          @(negedge Clk50);
          check_val("rnd_a_ac_pulse", a_ac, 0);
          a_rd = 1'b0; acs++;
          repeat ($urandom_range(1, 4)) @(negedge Clk50);
        end
      end
      begin
        int tv;
        logic [21:0] va;
        for (int k = 0; k < 12; k++) begin
          va = 22'($urandom); v_addr = va; v_rd = 1'b1;
          tv = 0;
          @(negedge Clk50);
          while (!v_ac && tv < 3000) begin @(negedge Clk50); tv++; end
          check_val("rnd_v_ac_seen", v_ac, 1);
          check_val("rnd_v_data", v_data, exp_word(va));
          @(negedge Clk50);
          check_val("rnd_v_ac_pulse", v_ac, 0);
          v_rd = 1'b0; acs++;
          repeat ($urandom_range(1, 4)) @(negedge Clk50);
        end
      end
    join
    junk_en = 1'b0;
    repeat (5) @(negedge Clk50);
    check_val("one_burst_per_req", bursts - b0, acs);
    check_val("rd_err_clear", rd_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
